// File: rtl/frac_div_pkg.sv
// Shared types and helpers for the fractional clock divider.
// States, the config record and the ratio-legality check live here so the
// top level and any future users agree on them.
package frac_div_pkg;

  // Widest ratio register the config record can carry. The divider's ACC_W
  // parameter must not exceed this; narrower values are zero-extended.
  localparam int FRAC_ACC_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } frac_state_e;

  typedef struct packed {
    logic [FRAC_ACC_W_MAX-1:0] num;
    logic [FRAC_ACC_W_MAX-1:0] den;
  } frac_cfg_t;

  // A ratio is usable when the denominator is non-zero and the ratio is <= 1.
  function automatic logic cfg_legal(input frac_cfg_t cfg);
    return (cfg.den != '0) && (cfg.num <= cfg.den);
  endfunction

endpackage

// File: rtl/frac_phase_acc.sv
// Phase accumulator core: adds NUM each step, wraps at DEN and flags a tick.
// hit is the combinational "this edge produces a tick" term; tick is its
// registered copy that leaves the block.
module frac_phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load_clear,
  input  logic             step,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             hit,
  output logic             tick
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;

  // Compare at one extra bit so acc+num can never wrap before the DEN test.
  assign sum = {1'b0, acc_q} + {1'b0, num};
  assign hit = step && (sum >= {1'b0, den});

  // On a hit acc+num-den equals acc-(den-num); with num<=den that stays in
  // range at ACC_W bits, and without a hit acc+num < den fits as well.
  always_comb begin
    acc_next = acc_q;
    if (hit) begin
      acc_next = acc_q - (den - num);
    end else if (step) begin
      acc_next = acc_q + num;
    end
  end

  // Accumulator and registered tick; a clear restarts the phase but still
  // lets the tick that caused it go out.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= hit;
      if (load_clear) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_next;
      end
    end
  end

endmodule

// File: rtl/frac_clk_divider.sv
// Runtime-programmable fractional clock divider.
// tick fires at an average rate NUM/DEN of clk_in; clk_out toggles per tick.
// New ratios arrive on a valid/ready port and are applied only on a tick
// boundary (or immediately when the divider is not running).
// Optional: define FRAC_CLK_DIV_TICK_CNT_EN to add a 32-bit tick_count output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | enable was low; accumulator frozen, configs apply directly
// RUN   | accumulating on the current ratio
// PEND  | new ratio staged in shadow, waits for the next old-ratio tick
module frac_clk_divider
  import frac_div_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int DEFAULT_NUM = 2,
  parameter int DEFAULT_DEN = 3
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_out,
  output logic             busy
`ifdef FRAC_CLK_DIV_TICK_CNT_EN
  ,
  output logic [31:0]      tick_count
`endif
);

  frac_state_e      state_q;
  frac_state_e      state_nxt;

  logic [ACC_W-1:0] num_q;
  logic [ACC_W-1:0] den_q;
  logic [ACC_W-1:0] sh_num_q;
  logic [ACC_W-1:0] sh_den_q;
  logic             err_q;
  logic             clk_q;

  logic             cfg_fire;
  logic             cfg_ok;
  frac_cfg_t        cfg_in;

  logic             hit;
  logic             capture;
  logic             apply_shadow;
  logic             apply_direct;
  logic             err_set;
  logic             err_clr;

  assign cfg_in    = '{num: FRAC_ACC_W_MAX'(cfg_num), den: FRAC_ACC_W_MAX'(cfg_den)};
  assign cfg_ok    = cfg_legal(cfg_in);
  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q == PEND);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_err   = err_q;
  assign clk_out   = clk_q;

  frac_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk_in     (clk_in),
    .reset      (reset),
    .load_clear (apply_shadow || apply_direct),
    .step       (enable),
    .num        (num_q),
    .den        (den_q),
    .hit        (hit),
    .tick       (tick)
  );

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state plus the apply/stage/error strobes for this edge.
  always_comb begin
    state_nxt    = state_q;
    capture      = 1'b0;
    apply_shadow = 1'b0;
    apply_direct = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;

    if (cfg_fire) begin
      if (cfg_ok) begin
        err_clr = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_fire && cfg_ok) begin
          apply_direct = 1'b1;
        end
        state_nxt = enable ? RUN : IDLE;
      end
      RUN: begin
        if (cfg_fire && cfg_ok && enable) begin
          // The tick of this same edge (if any) belongs to the old ratio.
          capture   = 1'b1;
          state_nxt = PEND;
        end else begin
          if (cfg_fire && cfg_ok) begin
            apply_direct = 1'b1;
          end
          state_nxt = enable ? RUN : IDLE;
        end
      end
      PEND: begin
        if (!enable) begin
          apply_shadow = 1'b1;
          state_nxt    = IDLE;
        end else if (hit) begin
          apply_shadow = 1'b1;
          state_nxt    = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Active ratio and shadow; reset drops any staged ratio.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      num_q    <= ACC_W'(DEFAULT_NUM);
      den_q    <= ACC_W'(DEFAULT_DEN);
      sh_num_q <= '0;
      sh_den_q <= '0;
    end else begin
      if (capture) begin
        sh_num_q <= cfg_num;
        sh_den_q <= cfg_den;
      end
      if (apply_shadow) begin
        num_q <= sh_num_q;
        den_q <= sh_den_q;
      end else if (apply_direct) begin
        num_q <= cfg_num;
        den_q <= cfg_den;
      end
    end
  end

  // Sticky reject flag, cleared by the next accepted ratio.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  // Output clock flips on every tick so it lines up with the tick register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clk_q <= 1'b0;
    end else if (hit) begin
      clk_q <= ~clk_q;
    end
  end

`ifdef FRAC_CLK_DIV_TICK_CNT_EN
  // Free-running tick counter; survives ratio changes, wraps naturally.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_count <= '0;
    end else if (hit) begin
      tick_count <= tick_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frac_clk_divider.sv
// Scoreboard bench for frac_clk_divider: the driver advances a ratio-level
// reference model each cycle and queues the expected outputs; a monitor
// pops and compares after every rising edge.
module tb_frac_clk_divider;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_num;
  logic [15:0] cfg_den;
  logic        cfg_err;
  logic        tick;
  logic        clk_out;
  logic        busy;
`ifdef FRAC_CLK_DIV_TICK_CNT_EN
  logic [31:0] tick_count;
`endif

  frac_clk_divider #(
    .ACC_W       (16),
    .DEFAULT_NUM (2),
    .DEFAULT_DEN (3)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .clk_out   (clk_out),
    .busy      (busy)
`ifdef FRAC_CLK_DIV_TICK_CNT_EN
    ,
    .tick_count(tick_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          tick;
    bit          clk_out;
    bit          ready;
    bit          err;
    bit          busy;
    int unsigned cnt;
    int          tag;   // 1: count ticks, 2: count and check the total
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   dut_ticks = 0;

  // Reference model state: the ratio in force, phase, staged ratio.
  int unsigned m_num, m_den, m_acc, m_sh_num, m_sh_den, m_cnt;
  bit          m_pend, m_err, m_clk, m_tick, m_run;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_num = 2; m_den = 3; m_acc = 0; m_sh_num = 0; m_sh_den = 0; m_cnt = 0;
    m_pend = 0; m_err = 0; m_clk = 0; m_tick = 0; m_run = 0;
  endtask

  // One rising edge of the divider, from the ratio rules.
  task automatic model_edge(input bit en, input bit v, input int unsigned n, input int unsigned d);
    bit hit;
    bit fire;
    hit  = en && (m_acc + m_num >= m_den);
    fire = v && !m_pend;
    if (en) m_acc = hit ? (m_acc + m_num - m_den) : (m_acc + m_num);
    m_tick = hit;
    if (hit) begin
      m_clk = ~m_clk;
      m_cnt = m_cnt + 1;
    end
    if (m_pend) begin
      if (!en || hit) begin
        m_num = m_sh_num; m_den = m_sh_den; m_acc = 0; m_pend = 0;
      end
    end else if (fire) begin
      if (d == 0 || n > d) begin
        m_err = 1;
      end else begin
        m_err = 0;
        if (m_run && en) begin
          m_sh_num = n; m_sh_den = d; m_pend = 1;
        end else begin
          m_num = n; m_den = d; m_acc = 0;
        end
      end
    end
    m_run = en;
  endtask

  // Drive one cycle of stimulus and queue what the next edge must show.
  task automatic cyc(input bit rst, input bit en, input bit v,
                     input int unsigned n, input int unsigned d, input int tag);
    exp_t e;
    bit   was_rst;
    @(negedge clk_in);
    was_rst   = reset;
    reset     = rst;
    enable    = en;
    cfg_valid = v;
    cfg_num   = n[15:0];
    cfg_den   = d[15:0];
    if (rst) model_reset();
    else     model_edge(en, v, n, d);
    e.tick = m_tick; e.clk_out = m_clk; e.ready = !m_pend; e.err = m_err;
    e.busy = m_pend; e.cnt = m_cnt; e.tag = tag;
    exp_q.push_back(e);
    if (rst && !was_rst) begin
      #1;
      chk("async_reset_tick", tick, 0);
      chk("async_reset_clk_out", clk_out, 0);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_ready", cfg_ready, 1);
    end
  endtask

  task automatic run(input int cycles, input bit en);
    for (int i = 0; i < cycles; i++) cyc(0, en, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int unsigned n, input int unsigned d);
    cyc(0, 1, 1, n, d, 0);
  endtask

  // Monitor: compare every observed edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick", tick, e.tick);
        chk("clk_out", clk_out, e.clk_out);
        chk("cfg_ready", cfg_ready, e.ready);
        chk("cfg_err", cfg_err, e.err);
        chk("busy", busy, e.busy);
`ifdef FRAC_CLK_DIV_TICK_CNT_EN
        chk("tick_count", tick_count, e.cnt);
`endif
        if (e.tag != 0 && tick) dut_ticks++;
        if (e.tag == 2) chk("ticks_in_30_cycles_at_2_3", dut_ticks, 20);
      end
    end
  end

  initial begin
    int unsigned n, d;
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_num = '0; cfg_den = '0;
    model_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Default 2/3 for 30 enabled cycles: 20 ticks expected.
    for (int i = 0; i < 29; i++) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 2);

    // 1/4 while running: staged until the next old-ratio tick.
    cfg(1, 4);
    run(20, 1);

    // Illegal ratios are rejected, then 3/3 clears the flag.
    cfg(0, 0);
    run(3, 1);
    cfg(5, 3);
    run(3, 1);
    cfg(3, 3);
    run(10, 1);

    // Freeze and resume.
    cfg(2, 5);
    run(7, 1);
    run(10, 0);
    run(12, 1);

    // Config while disabled applies directly.
    cyc(0, 0, 1, 3, 7, 0);
    run(10, 1);

    // Reset while a 1/4 is staged behind a slow 1/7.
    cfg(1, 7);
    run(9, 1);
    cfg(1, 4);
    run(1, 1);
    cyc(1, 0, 0, 0, 0, 0);
    run(15, 1);

    // 3/3 for 100 cycles.
    cfg(3, 3);
    run(100, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      n = $urandom_range(0, 9);
      d = $urandom_range(0, 9);
      if ($urandom_range(0, 299) == 0)
        cyc(1, 0, 0, 0, 0, 0);
      else
        cyc(0, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, n, d, 0);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_in);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
